// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS controller: opcodes, functs, FSM states,
// ALU operation codes and the per-state control word.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10,
    ALUOP_OR    = 2'b11
  } aluop_t;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11,
    S_ORIEX   = 4'd12,
    S_BNEEX   = 4'd13
  } state_t;

  // need_ready marks states whose strobes (irwrite/pcwrite/done) wait for memory.
  typedef struct packed {
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       immzext;
    logic [1:0] pcsrc;
    aluop_t     aluop;
    logic       pcwrite;
    logic       branch;
    logic       bne;
    logic       done;
    logic       need_ready;
  } ctrl_t;

  function automatic ctrl_t ctrl_of(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.alusrcb    = 2'b01;
        c.irwrite    = 1'b1;
        c.pcwrite    = 1'b1;
        c.need_ready = 1'b1;
      end
      S_DECODE: c.alusrcb = 2'b11;
      S_MEMADR, S_ADDIEX: begin
        c.alusrca = 1'b1;
        c.alusrcb = 2'b10;
      end
      S_MEMRD: c.iord = 1'b1;
      S_MEMWB: begin
        c.memtoreg = 1'b1;
        c.regwrite = 1'b1;
        c.done     = 1'b1;
      end
      S_MEMWR: begin
        c.iord       = 1'b1;
        c.memwrite   = 1'b1;
        c.done       = 1'b1;
        c.need_ready = 1'b1;
      end
      S_RTYPEEX: begin
        c.alusrca = 1'b1;
        c.aluop   = ALUOP_FUNCT;
      end
      S_RTYPEWB: begin
        c.regdst   = 1'b1;
        c.regwrite = 1'b1;
        c.done     = 1'b1;
      end
      S_ADDIWB: begin
        c.regwrite = 1'b1;
        c.done     = 1'b1;
      end
      S_BEQEX, S_BNEEX: begin
        c.alusrca = 1'b1;
        c.aluop   = ALUOP_SUB;
        c.pcsrc   = 2'b01;
        c.branch  = (s == S_BEQEX);
        c.bne     = (s == S_BNEEX);
        c.done    = 1'b1;
      end
      S_ORIEX: begin
        c.alusrca = 1'b1;
        c.alusrcb = 2'b10;
        c.immzext = 1'b1;
        c.aluop   = ALUOP_OR;
      end
      S_JEX: begin
        c.pcsrc   = 2'b10;
        c.pcwrite = 1'b1;
        c.done    = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mc_controller_if.sv
// Control bus between the instruction register/datapath and the multicycle controller.
// master = controller side, slave = datapath side.
interface mc_controller_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;

  logic       pcen;
  logic       iord;
  logic       memwrite;
  logic       irwrite;
  logic       regdst;
  logic       memtoreg;
  logic       regwrite;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic       immzext;
  logic [1:0] pcsrc;
  logic [2:0] alucontrol;
  logic       illegal_op;
  logic       instr_done;

  modport master (
    input  op, funct, zero, mem_ready,
    output pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
           alusrca, alusrcb, immzext, pcsrc, alucontrol, illegal_op, instr_done
  );

  modport slave (
    output op, funct, zero, mem_ready,
    input  pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
           alusrca, alusrcb, immzext, pcsrc, alucontrol, illegal_op, instr_done
  );
endinterface

// File: rtl/mc_aludec.sv
// ALU decoder: maps the FSM's aluop class and the R-type funct field to alucontrol.
// Unknown functs fall back to add rather than trapping.
module mc_aludec
  import mips_pkg::*;
(
  input  aluop_t     aluop_i,
  input  logic [5:0] funct_i,
  output logic [2:0] alucontrol_o
);

  always_comb begin
    alucontrol_o = ALU_ADD;
    case (aluop_i)
      ALUOP_ADD: alucontrol_o = ALU_ADD;
      ALUOP_SUB: alucontrol_o = ALU_SUB;
      ALUOP_OR:  alucontrol_o = ALU_OR;
      ALUOP_FUNCT: begin
        case (funct_i)
          FN_ADD:  alucontrol_o = ALU_ADD;
          FN_SUB:  alucontrol_o = ALU_SUB;
          FN_AND:  alucontrol_o = ALU_AND;
          FN_OR:   alucontrol_o = ALU_OR;
          FN_SLT:  alucontrol_o = ALU_SLT;
          default: alucontrol_o = ALU_ADD;
        endcase
      end
      default: alucontrol_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS control unit: Moore FSM sequencing each instruction over 3-5 cycles,
// with memory wait-states, optional bne/ori, illegal-opcode and retire pulses.
module mc_controller
  import mips_pkg::*;
#(
  parameter bit MEM_WAIT    = 1'b1,
  parameter bit SUPPORT_BNE = 1'b1,
  parameter bit SUPPORT_ORI = 1'b1
) (
  input  logic           clk,
  input  logic           reset,
  mc_controller_if.master bus
);

  state_t     state_q, state_d;
  ctrl_t      ctrl_q;
  logic       ready;
  logic       op_legal;
  logic       run;
  logic       strobe_ok;
  logic [2:0] alucontrol_raw;

  always_comb begin
    ready = MEM_WAIT ? bus.mem_ready : 1'b1;
  end

  always_comb begin
    op_legal = 1'b0;
    case (bus.op)
      OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J: op_legal = 1'b1;
      OP_BNE:  op_legal = SUPPORT_BNE;
      OP_ORI:  op_legal = SUPPORT_ORI;
      default: op_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  state_d = ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        state_d = S_FETCH;
        if (op_legal) begin
          case (bus.op)
            OP_LW, OP_SW: state_d = S_MEMADR;
            OP_RTYPE:     state_d = S_RTYPEEX;
            OP_BEQ:       state_d = S_BEQEX;
            OP_BNE:       state_d = S_BNEEX;
            OP_ADDI:      state_d = S_ADDIEX;
            OP_ORI:       state_d = S_ORIEX;
            OP_J:         state_d = S_JEX;
            default:      state_d = S_FETCH;
          endcase
        end
      end
      S_MEMADR:  state_d = (bus.op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   state_d = ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:   state_d = ready ? S_FETCH : S_MEMWR;
      S_RTYPEEX: state_d = S_RTYPEWB;
      S_ADDIEX:  state_d = S_ADDIWB;
      S_ORIEX:   state_d = S_ADDIWB;
      default:   state_d = S_FETCH;
    endcase
  end

  // The control word is registered alongside the state so outputs never glitch on decode.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      ctrl_q  <= ctrl_of(S_FETCH);
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_of(state_d);
    end
  end

  mc_aludec u_aludec (
    .aluop_i      (ctrl_q.aluop),
    .funct_i      (bus.funct),
    .alucontrol_o (alucontrol_raw)
  );

  assign run       = ~reset;
  assign strobe_ok = ~ctrl_q.need_ready | ready;

  assign bus.pcen = run & ((ctrl_q.pcwrite & strobe_ok)
                         | (ctrl_q.branch & bus.zero)
                         | (ctrl_q.bne & ~bus.zero));
  assign bus.iord       = run & ctrl_q.iord;
  assign bus.memwrite   = run & ctrl_q.memwrite;
  assign bus.irwrite    = run & ctrl_q.irwrite & strobe_ok;
  assign bus.regdst     = run & ctrl_q.regdst;
  assign bus.memtoreg   = run & ctrl_q.memtoreg;
  assign bus.regwrite   = run & ctrl_q.regwrite;
  assign bus.alusrca    = run & ctrl_q.alusrca;
  assign bus.alusrcb    = {2{run}} & ctrl_q.alusrcb;
  assign bus.immzext    = run & ctrl_q.immzext;
  assign bus.pcsrc      = {2{run}} & ctrl_q.pcsrc;
  assign bus.alucontrol = {3{run}} & alucontrol_raw;
  assign bus.illegal_op = run & (state_q == S_DECODE) & ~op_legal;
  assign bus.instr_done = run & ctrl_q.done & strobe_ok;

endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench for mc_controller: a full-featured instance and one without bne
// share stimulus; a reference model predicts every output each cycle.
module tb_mc_controller;

  localparam logic [5:0] T_R    = 6'b000000;
  localparam logic [5:0] T_J    = 6'b000010;
  localparam logic [5:0] T_BEQ  = 6'b000100;
  localparam logic [5:0] T_BNE  = 6'b000101;
  localparam logic [5:0] T_ADDI = 6'b001000;
  localparam logic [5:0] T_ORI  = 6'b001101;
  localparam logic [5:0] T_LW   = 6'b100011;
  localparam logic [5:0] T_SW   = 6'b101011;
  localparam logic [5:0] T_BAD  = 6'b111111;

  typedef struct packed {
    logic [17:0] o1;
    logic [3:0]  s1;
    logic [17:0] o2;
    logic [3:0]  s2;
    logic [15:0] cyc;
  } exp_t;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;
  exp_t sb[$];
  logic [3:0]  ms1, ms2;
  logic [15:0] cyc;

  mc_controller_if bus1 ();
  mc_controller_if bus2 ();

  mc_controller #(.MEM_WAIT(1'b1), .SUPPORT_BNE(1'b1), .SUPPORT_ORI(1'b1)) dut (
    .clk(clk), .reset(reset), .bus(bus1.master)
  );
  mc_controller #(.MEM_WAIT(1'b1), .SUPPORT_BNE(1'b0), .SUPPORT_ORI(1'b1)) dut_nobne (
    .clk(clk), .reset(reset), .bus(bus2.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic legal(input logic [5:0] op, input logic sup_bne);
    return (op == T_LW) || (op == T_SW) || (op == T_R) || (op == T_BEQ) ||
           (op == T_ADDI) || (op == T_J) || (op == T_ORI) || (sup_bne && op == T_BNE);
  endfunction

  // Output vector: {pcen,iord,memwrite,irwrite,regdst,memtoreg,regwrite,alusrca,
  //                 alusrcb[1:0],immzext,pcsrc[1:0],alucontrol[2:0],illegal_op,instr_done}
  function automatic logic [17:0] model_out(input logic [3:0] s, input logic [5:0] op,
      input logic [5:0] fn, input logic zero, input logic ready, input logic rst,
      input logic sup_bne);
    logic pcen, iord, memw, irw, regdst, m2r, regw, asa, imz, ill, done;
    logic [1:0] asb, pcs, aluop;
    logic [2:0] ac;
    {pcen, iord, memw, irw, regdst, m2r, regw, asa, imz, ill, done} = '0;
    asb = 2'b00; pcs = 2'b00; aluop = 2'b00;
    case (s)
      4'd0:  begin asb = 2'b01; irw = ready; pcen = ready; end
      4'd1:  begin asb = 2'b11; ill = !legal(op, sup_bne); end
      4'd2:  begin asa = 1'b1; asb = 2'b10; end
      4'd3:  iord = 1'b1;
      4'd4:  begin m2r = 1'b1; regw = 1'b1; done = 1'b1; end
      4'd5:  begin iord = 1'b1; memw = 1'b1; done = ready; end
      4'd6:  begin asa = 1'b1; aluop = 2'b10; end
      4'd7:  begin regdst = 1'b1; regw = 1'b1; done = 1'b1; end
      4'd8:  begin asa = 1'b1; aluop = 2'b01; pcs = 2'b01; pcen = zero; done = 1'b1; end
      4'd9:  begin asa = 1'b1; asb = 2'b10; end
      4'd10: begin regw = 1'b1; done = 1'b1; end
      4'd11: begin pcs = 2'b10; pcen = 1'b1; done = 1'b1; end
      4'd12: begin asa = 1'b1; asb = 2'b10; imz = 1'b1; aluop = 2'b11; end
      4'd13: begin asa = 1'b1; aluop = 2'b01; pcs = 2'b01; pcen = !zero; done = 1'b1; end
      default: ;
    endcase
    case (aluop)
      2'b00: ac = 3'b010;
      2'b01: ac = 3'b110;
      2'b11: ac = 3'b001;
      default: begin
        case (fn)
          6'b100000: ac = 3'b010;
          6'b100010: ac = 3'b110;
          6'b100100: ac = 3'b000;
          6'b100101: ac = 3'b001;
          6'b101010: ac = 3'b111;
          default:   ac = 3'b010;
        endcase
      end
    endcase
    if (rst) return 18'd0;
    return {pcen, iord, memw, irw, regdst, m2r, regw, asa, asb, imz, pcs, ac, ill, done};
  endfunction

  function automatic logic [3:0] model_next(input logic [3:0] s, input logic [5:0] op,
      input logic ready, input logic rst, input logic sup_bne);
    if (rst) return 4'd0;
    case (s)
      4'd0: return ready ? 4'd1 : 4'd0;
      4'd1: begin
        if (!legal(op, sup_bne)) return 4'd0;
        case (op)
          T_LW, T_SW: return 4'd2;
          T_R:        return 4'd6;
          T_BEQ:      return 4'd8;
          T_BNE:      return 4'd13;
          T_ADDI:     return 4'd9;
          T_ORI:      return 4'd12;
          T_J:        return 4'd11;
          default:    return 4'd0;
        endcase
      end
      4'd2:  return (op == T_LW) ? 4'd3 : 4'd5;
      4'd3:  return ready ? 4'd4 : 4'd3;
      4'd5:  return ready ? 4'd0 : 4'd5;
      4'd6:  return 4'd7;
      4'd9:  return 4'd10;
      4'd12: return 4'd10;
      default: return 4'd0;
    endcase
  endfunction

  function automatic logic [17:0] pack_bus1();
    return {bus1.pcen, bus1.iord, bus1.memwrite, bus1.irwrite, bus1.regdst, bus1.memtoreg,
            bus1.regwrite, bus1.alusrca, bus1.alusrcb, bus1.immzext, bus1.pcsrc,
            bus1.alucontrol, bus1.illegal_op, bus1.instr_done};
  endfunction

  function automatic logic [17:0] pack_bus2();
    return {bus2.pcen, bus2.iord, bus2.memwrite, bus2.irwrite, bus2.regdst, bus2.memtoreg,
            bus2.regwrite, bus2.alusrca, bus2.alusrcb, bus2.immzext, bus2.pcsrc,
            bus2.alucontrol, bus2.illegal_op, bus2.instr_done};
  endfunction

  task automatic step(input logic rst, input logic [5:0] op, input logic [5:0] fn,
                      input logic z, input logic rdy);
    exp_t e;
    @(posedge clk);
    #1;
    reset = rst;
    bus1.op = op; bus1.funct = fn; bus1.zero = z; bus1.mem_ready = rdy;
    bus2.op = op; bus2.funct = fn; bus2.zero = z; bus2.mem_ready = rdy;
    e.o1  = model_out(ms1, op, fn, z, rdy, rst, 1'b1);
    e.s1  = ms1;
    e.o2  = model_out(ms2, op, fn, z, rdy, rst, 1'b0);
    e.s2  = ms2;
    e.cyc = cyc;
    sb.push_back(e);
    ms1 = model_next(ms1, op, rdy, rst, 1'b1);
    ms2 = model_next(ms2, op, rdy, rst, 1'b0);
    cyc++;
  endtask

  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z, input int n);
    for (int i = 0; i < n; i++) step(1'b0, op, fn, z, 1'b1);
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check_eq($sformatf("c%0d dut.out", e.cyc), {14'd0, pack_bus1()}, {14'd0, e.o1});
      check_eq($sformatf("c%0d dut.state", e.cyc), {28'd0, 4'(dut.state_q)}, {28'd0, e.s1});
      check_eq($sformatf("c%0d nobne.out", e.cyc), {14'd0, pack_bus2()}, {14'd0, e.o2});
      check_eq($sformatf("c%0d nobne.state", e.cyc), {28'd0, 4'(dut_nobne.state_q)}, {28'd0, e.s2});
      $display("cycle %0d: op=%b funct=%b zero=%b ready=%b reset=%b out=%h state=%0d",
               e.cyc, bus1.op, bus1.funct, bus1.zero, bus1.mem_ready, reset,
               pack_bus1(), 4'(dut.state_q));
    end
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    cyc = 16'd0;
    ms1 = 4'd0;
    ms2 = 4'd0;
    reset = 1'b1;
    bus1.op = 6'd0; bus1.funct = 6'd0; bus1.zero = 1'b0; bus1.mem_ready = 1'b1;
    bus2.op = 6'd0; bus2.funct = 6'd0; bus2.zero = 1'b0; bus2.mem_ready = 1'b1;

    step(1'b1, T_R, 6'd0, 1'b0, 1'b1);
    step(1'b1, T_R, 6'd0, 1'b0, 1'b1);
    // lw: FETCH DECODE MEMADR MEMRD MEMWB
    run_instr(T_LW, 6'd0, 1'b0, 5);
    // sw with two wait cycles in MEMWR
    run_instr(T_SW, 6'd0, 1'b0, 3);
    step(1'b0, T_SW, 6'd0, 1'b0, 1'b0);
    step(1'b0, T_SW, 6'd0, 1'b0, 1'b0);
    step(1'b0, T_SW, 6'd0, 1'b0, 1'b1);
    // slt with a fetch stall, then sub, then an unknown funct
    step(1'b0, T_R, 6'b101010, 1'b0, 1'b0);
    run_instr(T_R, 6'b101010, 1'b0, 4);
    run_instr(T_R, 6'b100010, 1'b0, 4);
    run_instr(T_R, 6'b000111, 1'b0, 4);
    // branches
    run_instr(T_BEQ, 6'd0, 1'b1, 3);
    run_instr(T_BEQ, 6'd0, 1'b0, 3);
    run_instr(T_BNE, 6'd0, 1'b1, 3);
    step(1'b1, T_BNE, 6'd0, 1'b0, 1'b1);
    run_instr(T_BNE, 6'd0, 1'b0, 3);
    step(1'b1, T_ADDI, 6'd0, 1'b0, 1'b1);
    run_instr(T_ADDI, 6'd0, 1'b0, 4);
    run_instr(T_ORI, 6'd0, 1'b0, 4);
    run_instr(T_J, 6'd0, 1'b0, 3);
    run_instr(T_BAD, 6'd0, 1'b0, 2);
    // reset held three cycles while stalled in MEMRD
    run_instr(T_LW, 6'd0, 1'b0, 3);
    step(1'b0, T_LW, 6'd0, 1'b0, 1'b0);
    step(1'b1, T_LW, 6'd0, 1'b0, 1'b0);
    step(1'b1, T_LW, 6'd0, 1'b0, 1'b0);
    step(1'b1, T_LW, 6'd0, 1'b0, 1'b0);
    run_instr(T_LW, 6'd0, 1'b0, 5);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    check_eq("scoreboard_drained", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
